neuron_sequencer: RTL
=====================

NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 24, pixel word width (3 x 8-bit channels); Addr_Depth, 12, memory address width; Weight_Percision, 5, per-channel signed weight width; NUM_PIXELS, 4096, pixels per classification (1..2^Addr_Depth).
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request one classification; sampled only in IDLE.
REQ-005 pause  input  1  suppresses issue of new memory reads; sampled only in FETCH.
REQ-006 bias_in  input  DATA_WIDTH  bias value, latched on accepted start.
REQ-007 mem_rd_en  output  1  memory read strobe; data returns exactly 1 cycle later.
REQ-008 mem_addr  output  Addr_Depth  shared pixel/weight address.
REQ-009 pixel_data  input  DATA_WIDTH  pixel read data.
REQ-010 weight_data  input  3*Weight_Percision  packed weights {w3,w2,w1}.
REQ-011 x_out, w_out, b_out  output  DATA_WIDTH / 3*Weight_Percision / DATA_WIDTH  registered operands to the neuron calculator.
REQ-012 acc_reset, acc_enable, get_result  output  1 each  calculator controls.
REQ-013 neuron_out  input  1  calculator decision bit, valid 1 cycle after get_result.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse; is_cat valid in the same cycle.
REQ-016 is_cat  output  1  registered classification; holds until the next done.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, FETCH, DRAIN, RESULT, CAPTURE, DONE.
REQ-018 IDLE: start=1 -> CLEAR, latch bias_in into b_out, clear address counter to 0; start=0 -> stay.
REQ-019 CLEAR: acc_reset=1 for exactly one cycle -> FETCH.
REQ-020 FETCH, pause=0: mem_rd_en=1, mem_addr=counter, counter increments; the cycle issuing NUM_PIXELS-1 -> DRAIN.
REQ-021 FETCH, pause=1: mem_rd_en=0, counter holds, state holds; in-flight data still completes per REQ-022.
REQ-022 Read issued in cycle t: pixel_data/weight_data captured at end of t+1 into x_out/w_out; acc_enable=1 in cycle t+2 only.
REQ-023 acc_enable SHALL be high exactly NUM_PIXELS cycles per classification, never outside a valid operand cycle.
REQ-024 DRAIN: held exactly 2 cycles so the last acc_enable completes -> RESULT.
REQ-025 RESULT: get_result=1 for one cycle -> CAPTURE.
REQ-026 CAPTURE: is_cat <= neuron_out at end of cycle -> DONE.
REQ-027 DONE: done=1 for one cycle -> IDLE.
REQ-028 Latency, no pause: start sampled cycle 0 -> done in cycle NUM_PIXELS+6; each paused FETCH cycle adds exactly 1.
REQ-029 Counter SHALL never exceed NUM_PIXELS-1 and never wrap; NUM_PIXELS=2^Addr_Depth issues address all-ones last.
REQ-030 start while busy SHALL be ignored (not queued); pause outside FETCH SHALL be ignored.
REQ-031 x_out/w_out hold their last captured values when no data returns; b_out changes only on accepted start.

Reset
REQ-032 reset=1 at any clock edge SHALL force IDLE, counter=0, and drive mem_rd_en, acc_reset, acc_enable, get_result, busy, done, is_cat, x_out, w_out, b_out to 0, overriding all other inputs, including mid-FETCH; in-flight read data is discarded.
REQ-033 First start after reset release SHALL run a complete classification from address 0.

Verification (NUM_PIXELS=4)
REQ-034 start at cycle 0, pause=0 -> acc_reset cycle 1; mem_addr 0,1,2,3 in cycles 2-5; acc_enable cycles 4-7; get_result cycle 8; done cycle 10.
REQ-035 pause=1 in cycles 3-4 -> addresses 0,1,1(held),1,2,3 pattern with mem_rd_en low in 3-4; exactly 4 acc_enable pulses; done cycle 12.
REQ-036 neuron_out=1 in cycle 9 -> is_cat=1 with done cycle 10; next run with neuron_out=0 -> is_cat stays 1 until its done, then 0.
REQ-037 start pulsed in cycles 3 and 9 of a run -> ignored; single done at cycle 10; busy low cycle 11.
REQ-038 reset in cycle 4 -> cycle 5 all outputs 0, IDLE; no acc_enable after; new start -> mem_addr restarts at 0.
REQ-039 bias_in=0x123456 at start, changed later -> b_out=0x123456 for whole run.

Source files
------------

// File: rtl/neuron_sequencer.sv
// Sequences one neuron classification: clears the accumulator, streams NUM_PIXELS
// pixel/weight pairs through a 1-cycle-latency memory, then samples the decision bit.
//
// state   | meaning
// IDLE    | waiting for start; b_out latched and address cleared on accept
// CLEAR   | one-cycle accumulator reset
// FETCH   | issue one read per unpaused cycle, addresses 0..NUM_PIXELS-1
// DRAIN   | two cycles for the last read's data and accumulate to land
// RESULT  | ask the calculator for its decision
// CAPTURE | register neuron_out into is_cat
// DONE    | one-cycle done pulse alongside the new is_cat
module neuron_sequencer #(
    parameter int DATA_WIDTH       = 24,
    parameter int Addr_Depth       = 12,
    parameter int Weight_Percision = 5,
    parameter int NUM_PIXELS       = 4096
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          pause,
    input  logic [DATA_WIDTH-1:0]         bias_in,
    output logic                          mem_rd_en,
    output logic [Addr_Depth-1:0]         mem_addr,
    input  logic [DATA_WIDTH-1:0]         pixel_data,
    input  logic [3*Weight_Percision-1:0] weight_data,
    output logic [DATA_WIDTH-1:0]         x_out,
    output logic [3*Weight_Percision-1:0] w_out,
    output logic [DATA_WIDTH-1:0]         b_out,
    output logic                          acc_reset,
    output logic                          acc_enable,
    output logic                          get_result,
    input  logic                          neuron_out,
    output logic                          busy,
    output logic                          done,
    output logic                          is_cat
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        FETCH   = 3'd2,
        DRAIN   = 3'd3,
        RESULT  = 3'd4,
        CAPTURE = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [Addr_Depth-1:0] LAST_ADDR = Addr_Depth'(NUM_PIXELS - 1);

    state_t                state, state_nxt;
    logic [Addr_Depth-1:0] addr_cnt, addr_cnt_nxt;
    logic                  drain_cnt, drain_cnt_nxt;
    logic                  rd_d1;
    logic                  latch_bias;
    logic                  capture;

    always_comb begin
        state_nxt     = state;
        addr_cnt_nxt  = addr_cnt;
        drain_cnt_nxt = drain_cnt;
        mem_rd_en     = 1'b0;
        acc_reset     = 1'b0;
        get_result    = 1'b0;
        done          = 1'b0;
        latch_bias    = 1'b0;
        capture       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = CLEAR;
                    addr_cnt_nxt = '0;
                    latch_bias   = 1'b1;
                end
            end
            CLEAR: begin
                acc_reset = 1'b1;
                state_nxt = FETCH;
            end
            FETCH: begin
                if (!pause) begin
                    mem_rd_en = 1'b1;
                    // last address holds in the counter so it can never wrap
                    if (addr_cnt == LAST_ADDR) begin
                        state_nxt     = DRAIN;
                        drain_cnt_nxt = 1'b1;
                    end else begin
                        addr_cnt_nxt = addr_cnt + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == 1'b0) begin
                    state_nxt = RESULT;
                end else begin
                    drain_cnt_nxt = drain_cnt - 1'b1;
                end
            end
            RESULT: begin
                get_result = 1'b1;
                state_nxt  = CAPTURE;
            end
            CAPTURE: begin
                capture   = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_addr = addr_cnt;
    assign busy     = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            addr_cnt   <= '0;
            drain_cnt  <= 1'b0;
            rd_d1      <= 1'b0;
            acc_enable <= 1'b0;
            x_out      <= '0;
            w_out      <= '0;
            b_out      <= '0;
            is_cat     <= 1'b0;
        end else begin
            state      <= state_nxt;
            addr_cnt   <= addr_cnt_nxt;
            drain_cnt  <= drain_cnt_nxt;
            rd_d1      <= mem_rd_en;
            acc_enable <= rd_d1;
            if (rd_d1) begin
                x_out <= pixel_data;
                w_out <= weight_data;
            end
            if (latch_bias) b_out  <= bias_in;
            if (capture)    is_cat <= neuron_out;
        end
    end

endmodule
